// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//
// Multi-channel button conditioner. Each raw pin is synchronised, then
// debounced on a shared sampling strobe ("tick") made by a free-running
// prescaler. Each channel produces a debounced level, a one-clk edge pulse
// filtered by a common edge-select mode, and a one-shot long-press pulse.
// All logic runs on the single clock clk.
//
// Parameters:
//   CHANNELS          number of independent button channels (1..16)
//   ACTIVE_LOW        1: pin low means pressed, 0: pin high means pressed
//   PRESCALE_BITS     prescaler width, tick period = 2^PRESCALE_BITS clks
//   DEBOUNCE_SAMPLES  consecutive differing ticks needed to accept a change
//   HOLD_TICKS        ticks a press must last before long_press fires
//
// Ports:
//   clk         in   system clock, posedge
//   reset       in   synchronous active-high reset
//   buttons     in   [CHANNELS] raw asynchronous pin levels
//   mode        in   [2] edge select: 00 rise, 01 fall, 10 both, 11 none
//   pressed     out  [CHANNELS] debounced level, 1 = pressed
//   edge_pulse  out  [CHANNELS] one-clk pulse on a selected transition
//   long_press  out  [CHANNELS] one-clk pulse when hold threshold reached
//   tick        out  one-clk sampling strobe
// -----------------------------------------------------------------------------
module multi_edge_detect #(
  parameter int CHANNELS         = 2,
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter int PRESCALE_BITS    = 21,
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter int HOLD_TICKS       = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] buttons,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] edge_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic                tick
);

  // Pin level that means "not pressed"; the synchroniser resets to it so no
  // phantom press is seen when reset releases.
  localparam logic [CHANNELS-1:0]      INACTIVE   = {CHANNELS{ACTIVE_LOW}};
  localparam logic [3:0]               DEB_LIMIT  = 4'(DEBOUNCE_SAMPLES);
  localparam logic [15:0]              HOLD_LIMIT = 16'(HOLD_TICKS);
  localparam logic [PRESCALE_BITS-1:0] PRE_MAX    = '1;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser and polarity normalisation
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] w_sample;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= INACTIVE;
      r_sync2 <= INACTIVE;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
    end
  end

  // 1 = pressed, regardless of pin polarity
  assign w_sample = r_sync2 ^ INACTIVE;

  // ---------------------------------------------------------------------------
  // Tick prescaler: tick is high for the clk after the counter is all-ones,
  // so the first tick after reset lands 2^PRESCALE_BITS clks later.
  // ---------------------------------------------------------------------------
  logic [PRESCALE_BITS-1:0] r_prescale;
  logic                     r_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_prescale <= r_prescale + 1'b1;
      r_tick     <= (r_prescale == PRE_MAX);
    end
  end

  assign tick = r_tick;

  // ---------------------------------------------------------------------------
  // Edge-select decode, shared by all channels. Sampled on the same cycle the
  // level updates, so a mode change only affects later edges.
  // ---------------------------------------------------------------------------
  logic w_rise_en;
  logic w_fall_en;

  always_comb begin
    w_rise_en = 1'b0;
    w_fall_en = 1'b0;
    case (mode_t'(mode))
      MODE_RISE: w_rise_en = 1'b1;
      MODE_FALL: w_fall_en = 1'b1;
      MODE_BOTH: begin
        w_rise_en = 1'b1;
        w_fall_en = 1'b1;
      end
      default: begin
        w_rise_en = 1'b0;
        w_fall_en = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce, edge and long-press logic
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] w_pressed;
  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] w_long;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [3:0]  r_deb_cnt;
    logic [3:0]  w_deb_cnt_next;
    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_cnt_next;
    logic        r_pressed;
    logic        r_edge;
    logic        r_long;
    logic        w_toggle;
    logic        w_edge_fire;
    logic        w_long_fire;

    // Debounce: count consecutive ticks on which the sample disagrees with
    // the accepted level; any agreeing tick restarts the count.
    always_comb begin
      w_deb_cnt_next = r_deb_cnt;
      w_toggle       = 1'b0;
      if (r_tick) begin
        if (w_sample[gi] == r_pressed) begin
          w_deb_cnt_next = 4'd0;
        end else if (r_deb_cnt + 4'd1 >= DEB_LIMIT) begin
          w_toggle       = 1'b1;
          w_deb_cnt_next = 4'd0;
        end else begin
          w_deb_cnt_next = r_deb_cnt + 4'd1;
        end
      end
    end

    // Hold counter. A release tick (toggle while pressed) wins over the
    // threshold, so a press released exactly at HOLD_TICKS never fires.
    // Saturation at HOLD_LIMIT gives one pulse per press with no repeat.
    always_comb begin
      w_hold_cnt_next = r_hold_cnt;
      w_long_fire     = 1'b0;
      if (!r_pressed || w_toggle) begin
        w_hold_cnt_next = 16'd0;
      end else if (r_tick && (r_hold_cnt < HOLD_LIMIT)) begin
        w_hold_cnt_next = r_hold_cnt + 16'd1;
        w_long_fire     = ((r_hold_cnt + 16'd1) == HOLD_LIMIT);
      end
    end

    // Registered alongside the level so the pulse coincides with the first
    // cycle that shows the new level.
    assign w_edge_fire = w_toggle && (r_pressed ? w_fall_en : w_rise_en);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_deb_cnt  <= 4'd0;
        r_hold_cnt <= 16'd0;
        r_pressed  <= 1'b0;
        r_edge     <= 1'b0;
        r_long     <= 1'b0;
      end else begin
        r_deb_cnt  <= w_deb_cnt_next;
        r_hold_cnt <= w_hold_cnt_next;
        r_pressed  <= r_pressed ^ w_toggle;
        r_edge     <= w_edge_fire;
        r_long     <= w_long_fire;
      end
    end

    assign w_pressed[gi] = r_pressed;
    assign w_edge[gi]    = r_edge;
    assign w_long[gi]    = r_long;
  end

  assign pressed    = w_pressed;
  assign edge_pulse = w_edge;
  assign long_press = w_long;

endmodule

// File: tb/tb_multi_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detect
//
// Directed bench for multi_edge_detect with PRESCALE_BITS=2 (tick every
// 4 clk), DEBOUNCE_SAMPLES=3, HOLD_TICKS=5, ACTIVE_LOW=1, CHANNELS=2.
// Expected cycle offsets are counted from a clk edge after which tick is
// visibly high (call it E); a pin change driven just after E reaches the
// debounce evaluations at E+5, E+9, E+13, so pressed shows the new level
// after E+13.
// -----------------------------------------------------------------------------
module tb_multi_edge_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] buttons;
  logic [1:0] mode;
  logic [1:0] pressed;
  logic [1:0] edge_pulse;
  logic [1:0] long_press;
  logic       tick;

  multi_edge_detect #(
    .CHANNELS        (2),
    .ACTIVE_LOW      (1'b1),
    .PRESCALE_BITS   (2),
    .DEBOUNCE_SAMPLES(3),
    .HOLD_TICKS      (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .mode      (mode),
    .pressed   (pressed),
    .edge_pulse(edge_pulse),
    .long_press(long_press),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Pulse / transition monitor, sampled on the falling edge
  int   ep_cnt[2]   = '{0, 0};
  int   lp_cnt[2]   = '{0, 0};
  int   rise_cnt[2] = '{0, 0};
  int   fall_cnt[2] = '{0, 0};
  logic [1:0] prev_pressed = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (edge_pulse[i] === 1'b1) ep_cnt[i]++;
      if (long_press[i] === 1'b1) lp_cnt[i]++;
      if (pressed[i] === 1'b1 && prev_pressed[i] === 1'b0) rise_cnt[i]++;
      if (pressed[i] === 1'b0 && prev_pressed[i] === 1'b1) fall_cnt[i]++;
    end
    prev_pressed = pressed;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leave the bench just after an edge where tick is high (bounded wait)
  task automatic align_tick();
    int k;
    k = 0;
    while (tick !== 1'b1 && k < 8) begin
      step(1);
      k++;
    end
    if (tick !== 1'b1) check_val("tick_timeout", 16'(tick), 16'd1);
  endtask

  int ep0_s, ep1_s, lp0_s, lp1_s, r0_s, f0_s, r1_s;
  logic [1:0] sweep_mode[3] = '{2'b01, 2'b10, 2'b11};
  int         sweep_ep_press[3] = '{0, 1, 0};
  int         sweep_ep_total[3] = '{1, 2, 0};

  initial begin
    reset   = 1'b1;
    buttons = 2'b00;
    mode    = 2'b00;

    // ---- Reset: outputs quiet even with both pins low (pressed) ----
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_val("reset_outs", 16'({pressed, edge_pulse, long_press, tick}), 16'd0);
    end
    reset   = 1'b0;
    buttons = 2'b11;
    step(3);
    check_val("tick_before_first", 16'(tick), 16'd0);
    step(1);
    check_val("first_tick_at_4", 16'(tick), 16'd1);

    // ---- Clean press on ch0, mode 00, plus long press ----
    ep1_s = ep_cnt[1]; r1_s = rise_cnt[1]; lp0_s = lp_cnt[0]; lp1_s = lp_cnt[1];
    align_tick();
    buttons[0] = 1'b0;
    step(12);
    check_val("press_e12_pressed", 16'(pressed[0]), 16'd0);
    step(1);
    check_val("press_e13_pressed", 16'(pressed[0]), 16'd1);
    check_val("press_e13_edge", 16'(edge_pulse[0]), 16'd1);
    step(1);
    check_val("press_e14_edge", 16'(edge_pulse[0]), 16'd0);
    step(18);
    check_val("long_e32", 16'(long_press[0]), 16'd0);
    step(1);
    check_val("long_e33", 16'(long_press[0]), 16'd1);
    step(1);
    check_val("long_e34", 16'(long_press[0]), 16'd0);
    step(20);
    check_val("long_once", 16'(lp_cnt[0] - lp0_s), 16'd1);
    check_val("ch1_pressed_quiet", 16'(pressed[1]), 16'd0);
    check_val("ch1_edges_quiet", 16'(ep_cnt[1] - ep1_s), 16'd0);
    check_val("ch1_long_quiet", 16'(lp_cnt[1] - lp1_s), 16'd0);

    // ---- Release ch0 under mode 00: level falls, no pulse ----
    align_tick();
    buttons[0] = 1'b1;
    step(12);
    check_val("rel_e12_pressed", 16'(pressed[0]), 16'd1);
    step(1);
    check_val("rel_e13_pressed", 16'(pressed[0]), 16'd0);
    check_val("rel_e13_edge", 16'(edge_pulse[0]), 16'd0);
    step(4);

    // ---- Glitch on ch1 lasting 2 tick periods ----
    ep1_s = ep_cnt[1]; r1_s = rise_cnt[1]; lp1_s = lp_cnt[1];
    align_tick();
    buttons[1] = 1'b0;
    step(8);
    buttons[1] = 1'b1;
    step(20);
    check_val("glitch_rise", 16'(rise_cnt[1] - r1_s), 16'd0);
    check_val("glitch_edges", 16'(ep_cnt[1] - ep1_s), 16'd0);
    check_val("glitch_long", 16'(lp_cnt[1] - lp1_s), 16'd0);

    // ---- Mode sweep on ch0 ----
    for (int m = 0; m < 3; m++) begin
      mode  = sweep_mode[m];
      ep0_s = ep_cnt[0]; r0_s = rise_cnt[0]; f0_s = fall_cnt[0]; lp0_s = lp_cnt[0];
      align_tick();
      buttons[0] = 1'b0;
      step(16);
      check_val($sformatf("mode%0d_press_rise", m), 16'(rise_cnt[0] - r0_s), 16'd1);
      check_val($sformatf("mode%0d_press_edges", m), 16'(ep_cnt[0] - ep0_s),
                16'(sweep_ep_press[m]));
      align_tick();
      buttons[0] = 1'b1;
      step(16);
      check_val($sformatf("mode%0d_rel_fall", m), 16'(fall_cnt[0] - f0_s), 16'd1);
      check_val($sformatf("mode%0d_total_edges", m), 16'(ep_cnt[0] - ep0_s),
                16'(sweep_ep_total[m]));
      check_val($sformatf("mode%0d_no_long", m), 16'(lp_cnt[0] - lp0_s), 16'd0);
    end

    // ---- Release tick coincides with the hold threshold: no long_press ----
    mode  = 2'b10;
    lp0_s = lp_cnt[0];
    align_tick();
    buttons[0] = 1'b0;
    step(13);
    check_val("bound_pressed", 16'(pressed[0]), 16'd1);
    step(7);
    check_val("bound_aligned", 16'(tick), 16'd1);
    buttons[0] = 1'b1;
    step(12);
    check_val("bound_e32", 16'({pressed[0], long_press[0]}), 16'b10);
    step(1);
    check_val("bound_e33", 16'({pressed[0], long_press[0]}), 16'b00);
    step(8);
    check_val("bound_no_long", 16'(lp_cnt[0] - lp0_s), 16'd0);

    // ---- Reset after 2 differing ticks restarts the debounce count ----
    mode = 2'b00;
    align_tick();
    buttons[0] = 1'b0;
    step(10);
    reset = 1'b1;
    step(2);
    check_val("midrst_outs", 16'({pressed, edge_pulse, long_press, tick}), 16'd0);
    reset = 1'b0;
    step(12);
    check_val("midrst_r12_pressed", 16'(pressed[0]), 16'd0);
    step(1);
    check_val("midrst_r13_pressed", 16'(pressed[0]), 16'd1);
    check_val("midrst_r13_edge", 16'(edge_pulse[0]), 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
